alu_cmd_sequencer: RTL

//  Initiator side of the alu_64bit operand/result interface. Buffers operation

---
 rtl/alu_cmd_sequencer_if.sv | 48 ++++
 rtl/alu_cmd_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Command, result and ALU-side signals of the alu_64bit command sequencer.
// Latency: none (wires only).
// Backpressure: cmd_valid/cmd_ready on commands, res_valid/res_ready on results.
interface alu_cmd_sequencer_if #(
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [63:0]      cmd_a;
    logic [63:0]      cmd_b;
    logic [3:0]       cmd_sel;
    logic [TAG_W-1:0] cmd_tag;

    logic             res_valid;
    logic             res_ready;
    logic [63:0]      res_data;
    logic [3:0]       res_flags;
    logic             res_err;
    logic [TAG_W-1:0] res_tag;

    logic             alu_enable;
    logic [63:0]      alu_a;
    logic [63:0]      alu_b;
    logic [3:0]       alu_sel;
    logic [63:0]      alu_out;
    logic             alu_carryout;
    logic             alu_zero;
    logic             alu_sign;
    logic             alu_overflow;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag,
        output cmd_ready,
        output res_valid, res_data, res_flags, res_err, res_tag,
        input  res_ready,
        output alu_enable, alu_a, alu_b, alu_sel,
        input  alu_out, alu_carryout, alu_zero, alu_sign, alu_overflow
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag,
        input  cmd_ready,
        input  res_valid, res_data, res_flags, res_err, res_tag,
        output res_ready,
        input  alu_enable, alu_a, alu_b, alu_sel,
        output alu_out, alu_carryout, alu_zero, alu_sign, alu_overflow
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues one at a time to alu_64bit, returns tagged results; traps divide-by-zero.
// Latency: ALU_LAT+2 cycles from FIFO pop to res_valid (1 cycle for a trapped divide).
// Backpressure: cmd_ready = FIFO not full; res_ready low holds the result while the FIFO keeps filling.
module alu_cmd_sequencer #(
    parameter int         DEPTH   = 4,
    parameter int         TAG_W   = 4,
    parameter int         ALU_LAT = 1,
    parameter logic [3:0] DIV_SEL = 4'b1110
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_cmd_sequencer_if.master    bus,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int          AW       = $clog2(DEPTH);
    localparam int          CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [3:0]       sel;
        logic [63:0]      b;
        logic [63:0]      a;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        rst_sync;
    logic              arst_n;
    cmd_t              mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    cmd_t              push_cmd;
    cmd_t              head;
    logic              push;
    logic              pop;
    logic              head_vld;
    logic              head_trap;
    logic [CNT_W-1:0]  cnt;

    // Reset asserts asynchronously but releases two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign arst_n = rst_sync[1];

    assign push_cmd      = '{tag: bus.cmd_tag, sel: bus.cmd_sel, b: bus.cmd_b, a: bus.cmd_a};
    assign bus.cmd_ready = (fifo_count != FULL_CNT);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign head_vld      = (fifo_count != '0);
    assign head          = mem[rd_ptr];
    assign head_trap     = (head.sel == DIV_SEL) && (head.b == 64'd0);
    // Popping straight out of RESP on the result handshake keeps the ALU busy back-to-back.
    assign pop           = head_vld && ((state == IDLE) || ((state == RESP) && bus.res_ready));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_cmd;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop) state_nxt = head_trap ? RESP : ISSUE;
            ISSUE:   state_nxt = (ALU_LAT > 1) ? WAIT : CAPTURE;
            WAIT:    if (cnt == CNT_W'(1)) state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP: begin
                if (bus.res_ready) begin
                    if (pop) state_nxt = head_trap ? RESP : ISSUE;
                    else     state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.alu_enable = 1'b0;
        bus.res_valid  = 1'b0;
        busy           = 1'b0;
        if (state == ISSUE) bus.alu_enable = 1'b1;
        if (state == RESP)  bus.res_valid  = 1'b1;
        if ((state != IDLE) || head_vld) busy = 1'b1;
    end

    // A trapped divide never reaches the ALU, so the operand registers keep the last issued op.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_sel   <= '0;
            bus.res_data  <= '0;
            bus.res_flags <= '0;
            bus.res_err   <= 1'b0;
            bus.res_tag   <= '0;
            cnt           <= '0;
        end else begin
            if (pop) begin
                bus.res_tag <= head.tag;
                if (head_trap) begin
                    bus.res_data  <= '0;
                    bus.res_flags <= '0;
                    bus.res_err   <= 1'b1;
                end else begin
                    bus.alu_a   <= head.a;
                    bus.alu_b   <= head.b;
                    bus.alu_sel <= head.sel;
                end
            end
            if (state == ISSUE) cnt <= CNT_W'(ALU_LAT - 1);
            if (state == WAIT)  cnt <= cnt - CNT_W'(1);
            if (state == CAPTURE) begin
                bus.res_data  <= bus.alu_out;
                bus.res_flags <= {bus.alu_carryout, bus.alu_zero, bus.alu_sign, bus.alu_overflow};
                bus.res_err   <= 1'b0;
            end
        end
    end
endmodule
